sdram_prefetch_buffer: RTL and testbench

// Wishbone-side line buffer between the user-project Wishbone slave port and sdram_controller.
// A read miss fetches the whole aligned line (LINE_WORDS words) through the controller's

---
 rtl/sdram_prefetch_buffer.sv | 197 +++++++++++++++++++
 tb/tb_sdram_prefetch_buffer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_prefetch_buffer.sv
// One-line read prefetch buffer between a Wishbone slave port and sdram_controller.
// Read misses fetch the aligned line word by word with early restart; writes go straight through.
module sdram_prefetch_buffer #(
  parameter int LINE_LOG2 = 3,
  parameter int ADDR_W    = 23
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_dat_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic              enable,
  input  logic              flush,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic [ADDR_W-1:0] ctrl_addr,
  output logic              ctrl_rw,
  output logic [31:0]       ctrl_data_in,
  output logic              ctrl_in_valid,
  input  logic              ctrl_busy,
  input  logic [31:0]       ctrl_data_out,
  input  logic              ctrl_out_valid,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
);
  localparam int LINE_WORDS = 1 << LINE_LOG2;
  localparam int TAG_W      = ADDR_W - LINE_LOG2 - 2;

  typedef enum logic [2:0] {S_IDLE, S_WR, S_FILL_REQ, S_FILL_WAIT, S_ACK} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [31:0]           r_buf [LINE_WORDS];
  logic [LINE_WORDS-1:0] r_word_valid;
  logic                  r_line_valid;
  logic                  r_flush_pend;
  logic [TAG_W-1:0]      r_tag;
  logic [LINE_LOG2-1:0]  r_idx;
  logic [LINE_LOG2-1:0]  r_ptr;
  logic [ADDR_W-1:0]     r_wr_addr;
  logic [31:0]           r_wr_data;
  logic [3:0]            r_wr_sel;
  logic                  r_wr_hit;
  logic                  r_ack;
  logic [31:0]           r_dat;
  logic [15:0]           r_hit_cnt;
  logic [15:0]           r_miss_cnt;

  logic                  w_req;
  logic [TAG_W-1:0]      w_adr_tag;
  logic [LINE_LOG2-1:0]  w_adr_idx;
  logic [LINE_LOG2-1:0]  w_wr_idx;
  logic                  w_flush_now;
  logic                  w_hit;
  logic                  w_fill_beat;
  logic                  w_last;
  logic                  w_early;
  logic                  w_wr_merge;
  logic                  w_unused;

  assign w_req       = wbs_stb_i & wbs_cyc_i & enable;
  assign w_adr_tag   = wbs_adr_i[ADDR_W-1:LINE_LOG2+2];
  assign w_adr_idx   = wbs_adr_i[LINE_LOG2+1:2];
  assign w_wr_idx    = r_wr_addr[LINE_LOG2+1:2];
  // A flush in the same cycle as a request (or one still pending) forces that request to miss.
  assign w_flush_now = flush | r_flush_pend;
  assign w_hit       = r_line_valid & r_word_valid[w_adr_idx] & (w_adr_tag == r_tag) & ~w_flush_now;
  assign w_fill_beat = (r_state == S_FILL_WAIT) & ctrl_out_valid;
  assign w_last      = &r_ptr;
  assign w_early     = w_fill_beat & (r_ptr == r_idx);
  assign w_wr_merge  = (r_state == S_WR) & ~ctrl_busy & r_wr_hit;
  assign w_unused    = ^{wbs_adr_i[31:ADDR_W], wbs_adr_i[1:0]};

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_next        = r_state;
    ctrl_in_valid = 1'b0;
    ctrl_rw       = 1'b0;
    ctrl_addr     = '0;
    ctrl_data_in  = '0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (wbs_we_i)   w_next = S_WR;
          else if (w_hit) w_next = S_ACK;
          else            w_next = S_FILL_REQ;
        end
      end
      S_WR: begin
        ctrl_in_valid = 1'b1;
        ctrl_rw       = 1'b1;
        ctrl_addr     = r_wr_addr;
        ctrl_data_in  = r_wr_data;
        if (!ctrl_busy) w_next = S_ACK;
      end
      S_FILL_REQ: begin
        ctrl_in_valid = 1'b1;
        ctrl_addr     = {r_tag, r_ptr, 2'b00};
        if (!ctrl_busy) w_next = S_FILL_WAIT;
      end
      S_FILL_WAIT: begin
        if (ctrl_out_valid) begin
          if (!w_last)               w_next = S_FILL_REQ;
          else if (r_ptr == r_idx)   w_next = S_ACK;
          else                       w_next = S_IDLE;
        end
      end
      S_ACK:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: the line storage has no reset; line_valid/word_valid gate every use of its contents.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      if (w_fill_beat) begin
        r_buf[r_ptr] <= ctrl_data_out;
      end else if (w_wr_merge) begin
        for (int b = 0; b < 4; b++) begin
          if (r_wr_sel[b]) r_buf[w_wr_idx][8*b +: 8] <= r_wr_data[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_word_valid <= '0;
      r_line_valid <= 1'b0;
      r_flush_pend <= 1'b0;
      r_tag        <= '0;
      r_idx        <= '0;
      r_ptr        <= '0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_wr_sel     <= '0;
      r_wr_hit     <= 1'b0;
      r_ack        <= 1'b0;
      r_dat        <= '0;
      r_hit_cnt    <= '0;
      r_miss_cnt   <= '0;
    end else begin
      r_ack <= (w_next == S_ACK) | w_early;
      if (r_state != S_IDLE && flush) r_flush_pend <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_flush_now) begin
            r_line_valid <= 1'b0;
            r_flush_pend <= 1'b0;
          end
          if (w_req) begin
            if (wbs_we_i) begin
              r_wr_addr <= {wbs_adr_i[ADDR_W-1:2], 2'b00};
              r_wr_data <= wbs_dat_i;
              r_wr_sel  <= wbs_sel_i;
              r_wr_hit  <= w_hit;
            end else if (w_hit) begin
              r_dat <= r_buf[w_adr_idx];
              if (~&r_hit_cnt) r_hit_cnt <= r_hit_cnt + 16'd1;
            end else begin
              r_line_valid <= 1'b0;
              r_word_valid <= '0;
              r_tag        <= w_adr_tag;
              r_idx        <= w_adr_idx;
              r_ptr        <= '0;
              if (~&r_miss_cnt) r_miss_cnt <= r_miss_cnt + 16'd1;
            end
          end
        end
        S_FILL_WAIT: begin
          if (ctrl_out_valid) begin
            r_word_valid[r_ptr] <= 1'b1;
            if (w_early) r_dat <= ctrl_data_out;
            if (w_last) r_line_valid <= 1'b1;
            else        r_ptr        <= r_ptr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;
  assign hit_cnt   = r_hit_cnt;
  assign miss_cnt  = r_miss_cnt;

endmodule

// File: tb/tb_sdram_prefetch_buffer.sv
// Directed bench for sdram_prefetch_buffer: a negedge-driven controller model returns
// 32'h5A00_0000 | addr for every read; expected values below are hand-computed.
module tb_sdram_prefetch_buffer;
  logic        clk = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = 4'h0;
  logic [31:0] wbs_dat_i = '0, wbs_adr_i = '0;
  logic        enable = 1'b1, flush = 1'b0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [22:0] ctrl_addr;
  logic        ctrl_rw, ctrl_in_valid;
  logic [31:0] ctrl_data_in;
  logic        ctrl_busy = 1'b0;
  logic [31:0] ctrl_data_out = '0;
  logic        ctrl_out_valid = 1'b0;
  logic [15:0] hit_cnt, miss_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sdram_prefetch_buffer #(.LINE_LOG2(3), .ADDR_W(23)) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_dat_i(wbs_dat_i), .wbs_adr_i(wbs_adr_i),
    .enable(enable), .flush(flush),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .ctrl_addr(ctrl_addr), .ctrl_rw(ctrl_rw), .ctrl_data_in(ctrl_data_in),
    .ctrl_in_valid(ctrl_in_valid), .ctrl_busy(ctrl_busy),
    .ctrl_data_out(ctrl_data_out), .ctrl_out_valid(ctrl_out_valid),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  // Controller model: busy for busy_per_req cycles per request, read data resp_lat cycles after accept.
  int          busy_per_req = 0;
  int          busy_left    = 0;
  int          resp_lat     = 2;
  int          resp_cnt     = 0;
  logic [31:0] resp_data    = '0;
  logic [31:0] rd_log [$];
  int          wr_count     = 0;
  logic [31:0] last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;

  initial forever begin
    @(negedge clk);
    ctrl_out_valid = 1'b0;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        ctrl_out_valid = 1'b1;
        ctrl_data_out  = resp_data;
      end
    end
    ctrl_busy = 1'b0;
    if (ctrl_in_valid) begin
      if (busy_left > 0) begin
        ctrl_busy = 1'b1;
        busy_left--;
      end else begin
        busy_left = busy_per_req;
        if (ctrl_rw) begin
          wr_count++;
          last_wr_addr = 32'(ctrl_addr);
          last_wr_data = ctrl_data_in;
        end else begin
          rd_log.push_back(32'(ctrl_addr));
          resp_cnt  = resp_lat;
          resp_data = 32'h5A00_0000 | 32'(ctrl_addr);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_busy(input int n);
    busy_per_req = n;
    busy_left    = n;
  endtask

  task automatic flush_pulse();
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
  endtask

  task automatic wb_cycle(input logic we, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] sel, output logic [31:0] rd, output int lat);
    @(negedge clk);
    wbs_adr_i = a; wbs_we_i = we; wbs_dat_i = d; wbs_sel_i = sel;
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!wbs_ack_o && lat < 100);
    rd = wbs_dat_o;
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    @(negedge clk);
    check("ack_pulse", 32'(wbs_ack_o), 32'd0);
  endtask

  task automatic do_read(input string tag, input logic [31:0] a, input logic [31:0] exp_d, input int exp_lat);
    logic [31:0] rd;
    int          lat;
    wb_cycle(1'b0, a, 32'h0, 4'hF, rd, lat);
    check({tag, "_data"}, rd, exp_d);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] sel, input int exp_lat);
    logic [31:0] rd;
    int          lat;
    wb_cycle(1'b1, a, d, sel, rd, lat);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic seen;
    repeat (3) @(negedge clk);
    wb_rst_i = 1'b0;
    check("rst_ack",  32'(wbs_ack_o), 32'd0);
    check("rst_dat",  wbs_dat_o, 32'd0);
    check("rst_iv",   32'(ctrl_in_valid), 32'd0);
    check("rst_addr", 32'(ctrl_addr), 32'd0);
    check("rst_rw",   32'(ctrl_rw), 32'd0);
    check("rst_hit",  32'(hit_cnt), 32'd0);
    check("rst_miss", 32'(miss_cnt), 32'd0);

    // Cold miss on word 0: one cycle to FILL_REQ, accept, two-cycle response, one-cycle ack.
    do_read("cold_100", 32'h100, 32'h5A00_0100, 4);
    check("cold_100_miss", 32'(miss_cnt), 32'd1);
    repeat (25) @(negedge clk);
    check("fill_reads", 32'(rd_log.size()), 32'd8);
    for (int i = 0; i < 8; i++) check("fill_order", rd_log[i], 32'h100 + 32'(4 * i));

    do_read("hit_114", 32'h114, 32'h5A00_0114, 1);
    check("hit_114_cnt", 32'(hit_cnt), 32'd1);
    check("hit_114_rd", 32'(rd_log.size()), 32'd8);
    check("hit_114_wr", 32'(wr_count), 32'd0);

    // Word 3 arrives on the 4th beat; the next request waits for the 8th beat and is then a hit.
    flush_pulse();
    do_read("cold_10c", 32'h10C, 32'h5A00_010C, 13);
    check("cold_10c_miss", 32'(miss_cnt), 32'd2);
    do_read("stall_118", 32'h118, 32'h5A00_0118, 11);
    check("stall_118_hit", 32'(hit_cnt), 32'd2);
    check("stall_118_rd", 32'(rd_log.size()), 32'd16);

    set_busy(2);
    do_write("wr_hit_104", 32'h104, 32'hAABB_CCDD, 4'b0011, 4);
    set_busy(0);
    check("wr_hit_cnt",  32'(wr_count), 32'd1);
    check("wr_hit_addr", last_wr_addr, 32'h104);
    check("wr_hit_data", last_wr_data, 32'hAABB_CCDD);
    do_read("merged_104", 32'h104, 32'h5A00_CCDD, 1);
    check("merged_104_hit", 32'(hit_cnt), 32'd3);

    do_write("wr_miss_400", 32'h400, 32'h1234_5678, 4'hF, 2);
    check("wr_miss_cnt",  32'(wr_count), 32'd2);
    check("wr_miss_addr", last_wr_addr, 32'h400);
    check("wr_miss_rd",   32'(rd_log.size()), 32'd16);
    do_read("hit_after_wmiss", 32'h114, 32'h5A00_0114, 1);
    check("hit_after_wmiss_cnt", 32'(hit_cnt), 32'd4);

    flush_pulse();
    do_read("refill_104", 32'h104, 32'h5A00_0104, 7);
    check("refill_104_miss", 32'(miss_cnt), 32'd3);
    repeat (25) @(negedge clk);
    check("refill_104_rd", 32'(rd_log.size()), 32'd24);

    // Flush arriving while a write is stalled on ctrl_busy is held and applied back in IDLE.
    set_busy(3);
    fork
      do_write("wr_flush_200", 32'h200, 32'h0BAD_F00D, 4'hF, 5);
      begin
        @(negedge clk); @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
      end
    join
    set_busy(0);
    check("wr_flush_addr", last_wr_addr, 32'h200);
    do_read("pend_flush_100", 32'h100, 32'h5A00_0100, 4);
    check("pend_flush_miss", 32'(miss_cnt), 32'd4);
    check("pend_flush_hit",  32'(hit_cnt), 32'd4);
    repeat (25) @(negedge clk);

    // Flush in the same cycle as a request to a valid line turns it into a miss.
    fork
      do_read("flush_req_108", 32'h108, 32'h5A00_0108, 10);
      begin
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
      end
    join
    check("flush_req_miss", 32'(miss_cnt), 32'd5);
    repeat (25) @(negedge clk);
    check("flush_req_rd", 32'(rd_log.size()), 32'd40);
    do_read("hit_11c", 32'h11C, 32'h5A00_011C, 1);
    check("hit_11c_cnt", 32'(hit_cnt), 32'd5);

    enable = 1'b0;
    @(negedge clk);
    wbs_adr_i = 32'h100; wbs_we_i = 1'b0; wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | wbs_ack_o | ctrl_in_valid;
    end
    check("disabled_quiet", 32'(seen), 32'd0);
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; enable = 1'b1;
    check("disabled_hit", 32'(hit_cnt), 32'd5);

    // Reset while waiting for the first fill beat; that beat then arrives with the DUT in IDLE.
    @(negedge clk);
    wbs_adr_i = 32'h300; wbs_we_i = 1'b0; wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    wb_rst_i = 1'b1;
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
    @(negedge clk);
    check("mid_rst_ack",  32'(wbs_ack_o), 32'd0);
    check("mid_rst_dat",  wbs_dat_o, 32'd0);
    check("mid_rst_iv",   32'(ctrl_in_valid), 32'd0);
    check("mid_rst_addr", 32'(ctrl_addr), 32'd0);
    check("mid_rst_hit",  32'(hit_cnt), 32'd0);
    check("mid_rst_miss", 32'(miss_cnt), 32'd0);
    wb_rst_i = 1'b0;
    @(negedge clk);
    check("late_resp_ack", 32'(wbs_ack_o), 32'd0);
    check("late_resp_iv",  32'(ctrl_in_valid), 32'd0);
    check("late_resp_rd",  32'(rd_log.size()), 32'd41);
    do_read("after_rst_300", 32'h300, 32'h5A00_0300, 4);
    check("after_rst_miss", 32'(miss_cnt), 32'd1);
    check("after_rst_hit",  32'(hit_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
